// File: rtl/fru_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fru_config_sequencer                                            |
// | Brief   : Stages a filterReduceUnit firmware image in a byte buffer and    |
// |           streams it over configId/configData with tracing paused.         |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module fru_config_sequencer #(
    parameter int          N                  = 8,
    parameter int          M                  = 8,
    parameter int          DATA_WIDTH         = 32,
    parameter int          MAX_CHAINS         = 4,
    parameter int          FUVRF_SIZE         = 4,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'h00,
    parameter logic [7:0]  IDLE_CONFIG_ID     = 8'hFF,
    parameter int          DRAIN_CYCLES       = 2,
    localparam int         FW_BYTES           = 3 * MAX_CHAINS,
    localparam int         TOTAL_BYTES        = FW_BYTES + FUVRF_SIZE * M * DATA_WIDTH / 8,
    localparam int         AW                 = $clog2(TOTAL_BYTES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          trace_en_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          start_i,
    input  logic          start_mode_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          tracing_o,
    output logic [7:0]    config_id_o,
    output logic [7:0]    config_data_o
);

    localparam int            DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [AW:0]   FW_LEN     = (AW+1)'(FW_BYTES);
    localparam logic [AW:0]   TOTAL_LEN  = (AW+1)'(TOTAL_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    if (IDLE_CONFIG_ID == PERSONAL_CONFIG_ID || N < 1 || DRAIN_CYCLES < 1) begin : g_bad_params
        $error("fru_config_sequencer: illegal parameter set");
    end

    state_t         state_q, state_d;
    logic [AW:0]    len_q, len_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           wr_ready_q, wr_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tracing_q, tracing_d;
    logic [7:0]     cfg_id_q, cfg_id_d;
    logic [7:0]     cfg_data_q, cfg_data_d;
    logic [7:0]     rd_byte;

    // Staging buffer survives reset so an aborted stream can be replayed.
    logic [7:0] mem_q [TOTAL_BYTES];

    always_ff @(posedge clk) begin
        if (wr_valid_i && wr_ready_q && ({1'b0, wr_addr_i} < TOTAL_LEN)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_byte = mem_q[cnt_q[AW-1:0]];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        cfg_data_d = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DRAIN;
                    len_d   = start_mode_i ? FW_LEN : TOTAL_LEN;
                    cnt_d   = '0;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                // The first byte is launched on the last drain edge so it lands with STREAM.
                if (drain_q == DRAIN_LAST) begin
                    state_d    = S_STREAM;
                    cfg_data_d = rd_byte;
                    cnt_d      = cnt_q + (AW+1)'(1);
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            S_STREAM: begin
                if (cnt_q == len_q) begin
                    state_d = S_GAP;
                end else begin
                    cfg_data_d = rd_byte;
                    cnt_d      = cnt_q + (AW+1)'(1);
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_GAP);
        tracing_d  = (state_d == S_IDLE) && trace_en_i;
        wr_ready_d = (state_d == S_IDLE);
        cfg_id_d   = (state_d == S_STREAM) ? PERSONAL_CONFIG_ID : IDLE_CONFIG_ID;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tracing_q  <= 1'b0;
            cfg_id_q   <= IDLE_CONFIG_ID;
            cfg_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tracing_q  <= tracing_d;
            cfg_id_q   <= cfg_id_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign wr_ready_o    = wr_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign tracing_o     = tracing_q;
    assign config_id_o   = cfg_id_q;
    assign config_data_o = cfg_data_q;

endmodule
`default_nettype wire
